// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: clear-sequencer state
// encodings, default geometry and a helper for locating fields in packed buses.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_NUM_WR = 1;

    // Lowest bit of field 'idx' in a bus of equally sized fields of 'width' bits
    function automatic int field_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: walks ptr from 1 to DEPTH-1, requesting a zero
// write for each register, and holds busy until the walk is complete.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

    clr_state_t        state;
    clr_state_t        next_state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] next_ptr;

    // State and pointer registers; reset restarts the sweep from register 1
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            ptr   <= FIRST_ADDR;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
        end
    end

    // Advance the pointer while clearing; leave CLEAR once the last register is written
    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        case (state)
            ST_CLEAR: begin
                if (ptr == LAST_ADDR) begin
                    next_state = ST_READY;
                end else begin
                    next_ptr = ptr + FIRST_ADDR;
                end
            end
            ST_READY: begin
                next_state = ST_READY;
            end
            default: begin
                next_state = ST_CLEAR;
            end
        endcase
    end

    // Busy covers the reset cycles themselves as well as the sweep
    always_comb begin
        busy     = rst || (state == ST_CLEAR);
        clr_we   = !rst && (state == ST_CLEAR);
        clr_addr = ptr;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file for the MIPS datapath: NUM_RD combinational read
// ports, NUM_WR write ports (higher port index wins on address collisions),
// register 0 reads as zero, and a post-reset clear sweep during which writes
// are dropped and reported.
// Optional build macro REGFILE_BYPASS_EN: forward same-cycle write data to
// matching read ports while READY.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_WR-1:0]        i_we,
    input  logic [NUM_WR*ADDR_W-1:0] i_waddr,
    input  logic [NUM_WR*DATA_W-1:0] i_wdata,
    input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
    output logic [NUM_RD*DATA_W-1:0] o_rdata,
    output logic                     o_busy,
    output logic                     o_wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_drop;

    logic [ADDR_W-1:0] waddr [NUM_WR];
    logic [DATA_W-1:0] wdata [NUM_WR];
    logic [ADDR_W-1:0] raddr [NUM_RD];
    logic [DATA_W-1:0] rdata [NUM_RD];

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk      (i_clk),
        .rst      (i_rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_unpack
        assign waddr[k] = i_waddr[field_lo(k, ADDR_W) +: ADDR_W];
        assign wdata[k] = i_wdata[field_lo(k, DATA_W) +: DATA_W];
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd_pack
        assign raddr[j] = i_raddr[field_lo(j, ADDR_W) +: ADDR_W];
        assign o_rdata[field_lo(j, DATA_W) +: DATA_W] = rdata[j];
    end

    // Array update: the sweep owns the array while busy; afterwards the write
    // ports apply in ascending order so the highest port index lands last
    always_ff @(posedge i_clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (!busy) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (i_we[k] && (waddr[k] != '0)) begin
                    mem[waddr[k]] <= wdata[k];
                end
            end
        end
    end

    // Flag any write request that arrived while the file could not accept it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= busy && (|i_we);
        end
    end

    // Read muxes: zero for register 0 or while busy, optionally forwarding write data
    always_comb begin
        for (int j = 0; j < NUM_RD; j++) begin
            rdata[j] = '0;
            if (!busy && (raddr[j] != '0)) begin
                rdata[j] = mem[raddr[j]];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < NUM_WR; k++) begin
                    if (i_we[k] && (waddr[k] == raddr[j])) begin
                        rdata[j] = wdata[k];
                    end
                end
`endif
            end
        end
    end

    assign o_busy    = busy;
    assign o_wr_drop = wr_drop;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (two read and two write ports). Stimulus
// pushes hand-computed expectations tagged with the cycle they apply to; a
// monitor on the falling edge pops and compares them against the DUT.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam int K_RDATA = 0;
    localparam int K_BUSY  = 1;
    localparam int K_DROP  = 2;

    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] value;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_WR-1:0]        we;
    logic [NUM_WR*ADDR_W-1:0] waddr;
    logic [NUM_WR*DATA_W-1:0] wdata;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic                     busy;
    logic                     wr_drop;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  cur_exp;
    string cur_name;

    int cycle_count  = 0;
    int vector_count = 0;
    int miss_count   = 0;

    regfile_mp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_we      (we),
        .i_waddr   (waddr),
        .i_wdata   (wdata),
        .i_raddr   (raddr),
        .o_rdata   (rdata),
        .o_busy    (busy),
        .o_wr_drop (wr_drop)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Cycle index used to tag expectations
    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] we_v,
                                 input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic [4:0] ra0, input logic [4:0] ra1);
        we    = we_v;
        waddr = {wa1, wa0};
        wdata = {wd1, wd0};
        raddr = {ra1, ra0};
    endtask

    task automatic expectOutput(input int kind, input int port,
                                input logic [31:0] value, input string name);
        exp_t e;
        e.cyc   = cycle_count;
        e.kind  = kind;
        e.port  = port;
        e.value = value;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic checkOutput(input exp_t e, input string name);
        logic [31:0] act;
        case (e.kind)
            K_RDATA: act = rdata[e.port*DATA_W +: DATA_W];
            K_BUSY:  act = {31'b0, busy};
            default: act = {31'b0, wr_drop};
        endcase
        vector_count++;
        if (act !== e.value) begin
            miss_count++;
            $display("[TB] FAIL %s port %0d cycle %0d: got %h, expected %h",
                     name, e.port, e.cyc, act, e.value);
        end
    endtask

    // Monitor: compare every expectation due in this cycle, mid-cycle
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cycle_count) begin
            cur_exp  = exp_q.pop_front();
            cur_name = name_q.pop_front();
            checkOutput(cur_exp, cur_name);
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        rst = 1'b1;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        step();

        // Reset state
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd0);
        expectOutput(K_BUSY, 0, 32'd1, "reset_busy");
        expectOutput(K_DROP, 0, 32'd0, "reset_drop");
        expectOutput(K_RDATA, 0, 32'h0, "reset_read");
        step();
        rst = 1'b0;

        // Initial sweep: busy for 31 cycles, write at sweep cycle 10 is dropped
        for (int i = 0; i < 31; i++) begin
            expectOutput(K_BUSY, 0, 32'd1, "sweep_busy");
            if (i == 10) applyStimulus(2'b01, 5'd3, 32'hCAFE_F00D, 5'd0, 32'h0, 5'd0, 5'd0);
            if (i == 11) begin
                expectOutput(K_DROP, 0, 32'd1, "sweep_drop_pulse");
                applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
            end
            if (i == 12) expectOutput(K_DROP, 0, 32'd0, "sweep_drop_end");
            step();
        end
        expectOutput(K_BUSY, 0, 32'd0, "ready_busy");
        expectOutput(K_DROP, 0, 32'd0, "ready_drop");

        // Port 0 write to 5; port 1 reads register 0
        applyStimulus(2'b01, 5'd5, 32'h1234_5678, 5'd0, 32'h0, 5'd5, 5'd0);
        expectOutput(K_RDATA, 0, BYPASS ? 32'h1234_5678 : 32'h0, "wr5_same_cycle");
        expectOutput(K_RDATA, 1, 32'h0, "rd_addr0");
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd0);
        expectOutput(K_RDATA, 0, 32'h1234_5678, "wr5_next");
        expectOutput(K_RDATA, 1, 32'h0, "rd_addr0_b");
        expectOutput(K_DROP, 0, 32'd0, "wr5_no_drop");
        step();

        // Both ports write 7: port 1 wins; the dropped write to 3 left it zero
        applyStimulus(2'b11, 5'd7, 32'hAAAA_0000, 5'd7, 32'h0000_BBBB, 5'd7, 5'd3);
        expectOutput(K_RDATA, 0, BYPASS ? 32'h0000_BBBB : 32'h0, "dual_wr7_same");
        expectOutput(K_RDATA, 1, 32'h0, "dropped_wr3");
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7);
        expectOutput(K_RDATA, 0, 32'h0000_BBBB, "dual_wr7_p0");
        expectOutput(K_RDATA, 1, 32'h0000_BBBB, "dual_wr7_p1");
        step();

        // Port 1 alone writes 20
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd20, 32'h55AA_33CC, 5'd20, 5'd5);
        expectOutput(K_RDATA, 0, BYPASS ? 32'h55AA_33CC : 32'h0, "wr20_same");
        expectOutput(K_RDATA, 1, 32'h1234_5678, "hold5");
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd20, 5'd7);
        expectOutput(K_RDATA, 0, 32'h55AA_33CC, "wr20");
        expectOutput(K_RDATA, 1, 32'h0000_BBBB, "hold7");
        step();

        // Write to register 0 is ignored without a drop pulse
        applyStimulus(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 5'd0, 5'd0);
        expectOutput(K_RDATA, 0, 32'h0, "wr0_same");
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd20);
        expectOutput(K_RDATA, 0, 32'h0, "wr0_read");
        expectOutput(K_DROP, 0, 32'd0, "wr0_no_drop");
        expectOutput(K_RDATA, 1, 32'h55AA_33CC, "hold20");
        step();

        // Same-cycle read of 9 (forwarded only in the bypass build)
        applyStimulus(2'b01, 5'd9, 32'hDEAD_BEEF, 5'd0, 32'h0, 5'd0, 5'd9);
        expectOutput(K_RDATA, 1, BYPASS ? 32'hDEAD_BEEF : 32'h0, "byp9_same");
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9);
        expectOutput(K_RDATA, 0, 32'hDEAD_BEEF, "wr9_p0");
        expectOutput(K_RDATA, 1, 32'hDEAD_BEEF, "wr9_p1");
        step();

        // Second reset, then another reset at sweep cycle 15
        rst = 1'b1;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        step();
        expectOutput(K_BUSY, 0, 32'd1, "rst2_busy");
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            expectOutput(K_BUSY, 0, 32'd1, "sweep2_busy");
            if (i == 0) begin
                applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd9);
                expectOutput(K_RDATA, 0, 32'h0, "busy_mask5");
                expectOutput(K_RDATA, 1, 32'h0, "busy_mask9");
            end
            if (i == 15) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        for (int i = 0; i < 31; i++) begin
            expectOutput(K_BUSY, 0, 32'd1, "restart_busy");
            step();
        end
        expectOutput(K_BUSY, 0, 32'd0, "restart_ready");

        // Every register reads zero after the sweep
        for (int a = 1; a < 32; a++) begin
            applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(a), 5'(32 - a));
            expectOutput(K_RDATA, 0, 32'h0, "cleared_p0");
            expectOutput(K_RDATA, 1, 32'h0, "cleared_p1");
            step();
        end

        // Let the monitor drain, bounded
        for (int t = 0; t < 4 && exp_q.size() > 0; t++) step();
        vector_count++;
        if (exp_q.size() != 0) begin
            miss_count++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
